range_frame_feeder: RTL

//  Upstream stage of the range finder. Collects a nibble-wide frame from chip input pins.

---
 rtl/range_pkg.sv | 8 +
 rtl/frame_buffer.sv | 32 +++
 rtl/range_frame_feeder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/range_pkg.sv
// Shared types and constants for the range finder front end.
package range_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DROP, BURST} feeder_state_t;

  localparam int MIN_FRAME = 2;

endpackage

// File: rtl/frame_buffer.sv
// Sample store for one frame: synchronous write port, registered read port.
module frame_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the feeder's data output, so it is reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/range_frame_feeder.sv
// Assembles nibble frames into samples, drops bad frames and replays good ones as a burst.
module range_frame_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH/2-1:0]   nib_in,
  input  logic                 nib_valid,
  input  logic                 sof,
  input  logic                 eof,
  output logic [WIDTH-1:0]     data_out,
  output logic                 go,
  output logic                 finish,
  output logic                 busy,
  output logic                 frame_err
);

  import range_pkg::*;

  localparam int NW = WIDTH / 2;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  feeder_state_t   state;
  logic [NW-1:0]   lo_nib;
  logic            have_lo;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   last_idx;
  logic            full;
  logic            we;
  logic [WIDTH-1:0] wdata;

  always_comb begin
    full  = (count == CW'(DEPTH));
    we    = (state == COLLECT) && nib_valid && !sof && have_lo && !full;
    wdata = {nib_in, lo_nib};
  end

  frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buffer (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (count[AW-1:0]),
    .wdata   (wdata),
    .raddr   (rd_idx),
    .rdata   (data_out)
  );

  // The first BURST cycle only issues the read of sample 0; busy/go follow one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lo_nib    <= '0;
      have_lo   <= 1'b0;
      count     <= '0;
      rd_idx    <= '0;
      last_idx  <= '0;
      go        <= 1'b0;
      finish    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (nib_valid && sof) begin
            state   <= COLLECT;
            lo_nib  <= nib_in;
            have_lo <= 1'b1;
            count   <= '0;
          end
        end
        COLLECT: begin
          if (nib_valid) begin
            if (sof) begin
              lo_nib  <= nib_in;
              have_lo <= 1'b1;
              count   <= '0;
            end else if (!have_lo) begin
              lo_nib  <= nib_in;
              have_lo <= 1'b1;
              if (eof) begin
                frame_err <= 1'b1;
                state     <= IDLE;
              end
            end else begin
              have_lo <= 1'b0;
              if (full) begin
                frame_err <= 1'b1;
                state     <= eof ? IDLE : DROP;
              end else begin
                count <= count + CW'(1);
                if (eof) begin
                  if (count >= CW'(MIN_FRAME - 1)) begin
                    state    <= BURST;
                    last_idx <= count[AW-1:0];
                    rd_idx   <= '0;
                  end else begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                  end
                end
              end
            end
          end
        end
        DROP: begin
          if (nib_valid && sof) begin
            state   <= COLLECT;
            lo_nib  <= nib_in;
            have_lo <= 1'b1;
            count   <= '0;
          end else if (nib_valid && eof) begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (!busy) begin
            go     <= 1'b1;
            busy   <= 1'b1;
            rd_idx <= rd_idx + AW'(1);
          end else if (finish) begin
            state  <= IDLE;
            busy   <= 1'b0;
            finish <= 1'b0;
            rd_idx <= '0;
          end else begin
            go     <= 1'b0;
            finish <= (rd_idx == last_idx);
            if (rd_idx != last_idx) begin
              rd_idx <= rd_idx + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
